// File: rtl/axi_ar_arbiter.sv
// rtl/axi_ar_arbiter.sv - AR/R read-channel arbiter between M0 and M1.
// Build option: ARB_RR_EN selects round-robin contention; otherwise M1 has fixed priority.
module axi_ar_arbiter #(
  parameter int MAX_BEATS = 16
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       ARVALID_M0,
  input  logic       ARVALID_M1,
  input  logic       ARREADY_S,
  input  logic       RVALID_S,
  input  logic       RREADY_M,
  input  logic       RLAST_S,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            last_served_q, last_served_d;
  logic [1:0]      grant_d;
  logic            busy_d, err_d;
  logic            win_m1, arv_sel, ar_hs, beat, last_beat, wd_fire;

  // Contention policy; a lone requester always wins.
  always_comb begin
    if (ARVALID_M0 && ARVALID_M1) begin
`ifdef ARB_RR_EN
      win_m1 = ~last_served_q;
`else
      win_m1 = 1'b1;
`endif
    end else begin
      win_m1 = ARVALID_M1;
    end
  end

  assign arv_sel   = grant[1] ? ARVALID_M1 : ARVALID_M0;
  assign ar_hs     = arv_sel && ARREADY_S;
  assign beat      = RVALID_S && RREADY_M;
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_beat = beat && RLAST_S;
  assign wd_fire   = beat && !RLAST_S && (cnt_inc == CW'(MAX_BEATS));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ARVALID_M0 || ARVALID_M1) state_d = ADDR;
      ADDR:    if (ar_hs) state_d = DATA;
      DATA:    if (last_beat || wd_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant;
    err_d         = 1'b0;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (ARVALID_M0 || ARVALID_M1) grant_d = win_m1 ? 2'b10 : 2'b01;
      end
      ADDR: begin
        if (ar_hs) cnt_d = '0;
      end
      DATA: begin
        if (beat) cnt_d = cnt_inc;
        if (last_beat || wd_fire) begin
          grant_d       = 2'b00;
          last_served_d = grant[1];
          err_d         = wd_fire;
        end
      end
      default: grant_d = 2'b00;
    endcase
    busy_d = |grant_d;
  end

  // Outputs are registered so the mux selects never glitch on input changes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      grant         <= 2'b00;
      busy          <= 1'b0;
      err           <= 1'b0;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
    end else begin
      grant         <= grant_d;
      busy          <= busy_d;
      err           <= err_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

endmodule

// File: doc/axi_ar_arbiter.md
# axi_ar_arbiter

Read-channel arbiter for the AXI interconnect: shares the single slave-side AR/R path between master M0 (instruction fetch) and master M1 (data access). It grants one master at a time and holds that grant from the AR handshake through the RLAST beat, so R beats are always routed to the master that issued the address. It sits beside the write-response arbitration in the bridge and drives the AR/R mux selects.

## Interface

Parameters:
- MAX_BEATS, default 16: maximum R beats per burst before the watchdog releases the grant.

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- ARVALID_M0  in  1  M0 address request.
- ARVALID_M1  in  1  M1 address request.
- ARREADY_S  in  1  ARREADY from the selected slave path.
- RVALID_S  in  1  RVALID from the selected slave path.
- RREADY_M  in  1  RREADY from the granted master, already muxed.
- RLAST_S  in  1  RLAST from the selected slave path.
- grant  out  2  one-hot select: 2'b01 = M0, 2'b10 = M1, 2'b00 = none.
- busy  out  1  high whenever grant != 2'b00.
- err  out  1  one-cycle pulse when the watchdog fires.

## Operation

- States: IDLE, ADDR, DATA.
- All outputs are registered.
- Beat counter width: $clog2(MAX_BEATS+1).
- last_served: 1-bit register holding the master granted most recently.

IDLE:
- grant=00, busy=0.
- If any ARVALID is high, load the winner into grant and go to ADDR.
- Single requester wins outright.
- Both requesting: winner per Configuration.

ADDR:
- grant is held.
- On ARVALID_sel & ARREADY_S: go to DATA and clear the beat counter.
- If the granted master drops ARVALID without a handshake (protocol violation), stay in ADDR and keep the grant. No re-arbitration.

DATA:
- Each RVALID_S & RREADY_M increments the beat counter.
- If that beat has RLAST_S=1:
  - go to IDLE, grant=00;
  - last_served = granted master.
- If the counter reaches MAX_BEATS on a beat without RLAST:
  - pulse err;
  - go to IDLE, grant=00;
  - update last_served.
- Beats with RVALID_S low or RREADY_M low do not count.

Other rules:
- ARVALID from the non-granted master is ignored until the state returns to IDLE. That master is not starved: the next IDLE arbitration uses last_served.
- Reset mid-transaction: on ARESET assertion, state=IDLE, grant=00, busy=0, err=0, counter=0 and last_served=M1, all immediately and asynchronously. No pending burst is completed.
- Reset values: grant=2'b00, busy=0, err=0, last_served=M1 (M0 therefore wins the first contended arbitration in round-robin mode).

## Timing

- Request sampled at edge N gives grant valid after edge N, visible in cycle N+1.
- AR handshake in cycle N: state is DATA from cycle N+1. A beat in cycle N+1 is accepted and counted.
- RLAST handshake in cycle N: grant=00 in cycle N+1.
- The earliest new grant is cycle N+2, a mandatory one-cycle dead slot between transactions.
- Single-beat burst with ARREADY and RVALID each available in the first cycle possible: AR handshake in cycle 1, RLAST beat in cycle 2, grant released in cycle 3. Total occupancy is 3 cycles including the dead slot.
- err is high for exactly the cycle after the terminating beat, coincident with grant=00.

## Configuration

- ARB_RR_EN defined: round-robin. Under contention, grant the master that is not last_served.
- ARB_RR_EN undefined: fixed priority, M1 always wins contention. last_served is still maintained but does not affect arbitration.

## Test plan

- Reset release, then ARVALID_M0=1 only; ARREADY_S=1 next cycle; 4 beats with RLAST on beat 4 → grant=01 for the whole burst, grant=00 the cycle after beat 4, busy tracks grant.
- Both ARVALID high from reset, ARB_RR_EN defined, four back-to-back single-beat bursts → grant sequence 01,10,01,10 with one 00 cycle between each.
- Same stimulus with ARB_RR_EN undefined → grant is 10 every time while M1 keeps requesting; M0 is granted only after ARVALID_M1 drops.
- M1 granted; ARVALID_M0 is asserted mid-burst; RVALID_S toggles 1,0,1 with RREADY_M=1 → grant stays 10, the counter counts 2 beats, M0 is granted only at the first IDLE arbitration after RLAST.
- MAX_BEATS=4; 4 beats with RLAST held low → err=1 for one cycle together with grant=00; the next request is arbitrated normally.
- ARESET pulsed while in DATA with 2 beats done → grant=00, busy=0 in the same cycle; after release, a contended request goes to M0 (RR mode).
